// File: rtl/br_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit saturating counters,
// execute-side mispredict/redirect generation and saturating performance counters.
module br_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_npc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_npc,
    input  logic        bp_flush,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_cnt,
    output logic [31:0] mis_cnt
);

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [31:0] br_cnt_q;
    logic [31:0] mis_cnt_q;

    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             fetch_hit;
    logic             upd_hit;
    logic [31:0]      correct_npc;

    // The carried prediction bit adds nothing beyond the full NPC compare.
    logic unused_pred_taken;
    assign unused_pred_taken = upd_pred_taken;

    assign fetch_idx = fetch_pc[IDX_W+1:2];
    assign fetch_tag = fetch_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_idx   = upd_pc[IDX_W+1:2];
    assign upd_tag   = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

    // Lookup reads registered state only, so a same-cycle update is not visible.
    assign fetch_hit  = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    assign pred_taken = fetch_hit && ctr_q[fetch_idx][1];
    assign pred_npc   = pred_taken ? target_q[fetch_idx] : fetch_pc + 32'd4;

    assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign correct_npc = upd_taken ? upd_target : upd_pc + 32'd4;
    assign mispredict  = upd_valid && (correct_npc != upd_pred_npc);
    assign redirect_pc = correct_npc;

    assign br_cnt  = br_cnt_q;
    assign mis_cnt = mis_cnt_q;

    // NOTE: the BTB arrays sit in the async reset so every entry starts invalid
    // with a cleared counter; tag and target are cleared too for determinism.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b00;
            end
        end else if (bp_flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b00;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    ctr_q[upd_idx]    <= (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
                    target_q[upd_idx] <= upd_target;
                end else begin
                    ctr_q[upd_idx] <= (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                // Allocation evicts whatever aliasing entry held this index.
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
                ctr_q[upd_idx]    <= 2'b10;
            end
        end
    end

    // Counters keep counting through a flush and stick at all-ones.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (upd_valid && (br_cnt_q != 32'hFFFF_FFFF)) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (mispredict && (mis_cnt_q != 32'hFFFF_FFFF)) begin
                mis_cnt_q <= mis_cnt_q + 32'd1;
            end
        end
    end

endmodule

// File: doc/br_predictor.md
Name: br_predictor

Overview:
- Fetch-side branch predictor and redirect generator for the LA32R pipeline.
- Consumes the branch resolution that the execute-stage taken/target logic produces for beq/blt/bl/jirl/b.
- Predicts next PC at fetch from a direct-mapped BTB holding 2-bit saturating counters.
- Learns from resolved branches; flags mispredicts with the correct redirect PC; keeps saturating performance counters.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, ≥2.
- IDX_W, 4, log2(ENTRIES).
- TAG_W, 8, tag bits taken from pc[IDX_W+2+TAG_W-1 : IDX_W+2].

Ports:
- clk  input  1  clock.
- resetn  input  1  asynchronous active-low reset.
- fetch_pc  input  32  PC being fetched this cycle.
- pred_taken  output  1  prediction: taken.
- pred_npc  output  32  predicted next PC.
- upd_valid  input  1  a resolved branch/jump is presented this cycle.
- upd_pc  input  32  PC of the resolved instruction.
- upd_taken  input  1  actual taken result from execute.
- upd_target  input  32  actual target when taken.
- upd_pred_taken  input  1  prediction carried down the pipe with the instruction.
- upd_pred_npc  input  32  predicted next PC carried down the pipe.
- bp_flush  input  1  invalidate all entries.
- mispredict  output  1  resolved outcome differs from prediction.
- redirect_pc  output  32  correct next PC when mispredict=1.
- br_cnt  output  32  resolved-branch count.
- mis_cnt  output  32  mispredict count.

Behaviour:
- Entry fields: valid, tag[TAG_W], target[32], ctr[2].
- Index = pc[IDX_W+1:2]; tag = pc[IDX_W+2+TAG_W-1:IDX_W+2].
- Reset (resetn=0, asynchronous): all valid=0, ctr=2'b00, br_cnt=0, mis_cnt=0. Target and tag are don't-care but are cleared to 0.
- Outputs while in reset:
  - pred_taken=0 and pred_npc=fetch_pc+4.
  - mispredict=0 if upd_valid=0.

Lookup (combinational, zero latency, reads registered state only, no bypass of a same-cycle update):
- hit = valid & tag match.
- pred_taken = hit & ctr[1].
- pred_npc = pred_taken ? target : fetch_pc+4 (32-bit wrap).

Resolve (combinational, qualified by upd_valid):
- correct_npc = upd_taken ? upd_target : upd_pc+4.
- mispredict = upd_valid & (correct_npc != upd_pred_npc).
- redirect_pc = correct_npc; redirect_pc is valid only when mispredict=1.
- upd_pred_taken is informational only; the compare uses the full NPC, so a taken branch predicted taken to the wrong target is a mispredict.

Update (posedge clk, upd_valid=1, bp_flush=0):
- Hit, taken: ctr saturating +1, max 3; target ← upd_target.
- Hit, not taken: ctr saturating −1, min 0; target unchanged; entry stays valid.
- Miss, taken: allocate. valid=1, tag and target written, ctr=2'b10. Overwrites any aliasing entry.
- Miss, not taken: no change.

Flush:
- bp_flush=1 at posedge: all valid ← 0, ctr ← 0. Flush wins over a same-cycle update.
- Performance counters still count during flush.

Counters (posedge clk):
- br_cnt += 1 when upd_valid.
- mis_cnt += 1 when mispredict.
- Both saturate at 32'hFFFFFFFF; no wrap.

Other boundary rules:
- Lookup and update of the same index in one cycle: lookup returns pre-update state.
- upd_valid=0: no state change except flush.
- Reset asserted mid-stream: state clears immediately, with no wait for a clock edge.

Test Plan:
- Reset then lookup: fetch_pc=0x1C000000 → pred_taken=0, pred_npc=0x1C000004; br_cnt=mis_cnt=0.
- Cold taken branch: upd pc=0x1C000010, taken=1, target=0x1C000100, pred_npc=0x1C000014 → mispredict=1, redirect_pc=0x1C000100. Next cycle, fetch_pc=0x1C000010 → pred_taken=1, pred_npc=0x1C000100; mis_cnt=1.
- Counter hysteresis on pc 0x1C000010:
  - Two not-taken updates → ctr 2→1→0; lookup predicts not taken (pred_npc=0x1C000014). The first of those updates, carrying pred_npc=0x1C000100, flags mispredict with redirect_pc=0x1C000014.
  - Then two taken updates → ctr 0→1→2; lookup predicts taken again.
- Alias eviction: a taken update at pc 0x1C000050 (same index 4, different tag) replaces the entry → fetch_pc=0x1C000010 misses (pred_npc=0x1C000014); fetch_pc=0x1C000050 hits.
- Same-cycle update and lookup at 0x1C000020: lookup shows old state. Flush asserted together with an update → all lookups miss next cycle; br_cnt still increments.
- Saturation: force br_cnt to 0xFFFFFFFE, apply 3 updates → br_cnt=0xFFFFFFFF. Assert resetn=0 between clock edges → counters read 0 immediately.
